// File: rtl/sprite_coord_fetch_if.sv
// Memory port A bus between the sprite-coordinate fetch controller and shared RAM.
// The controller is the master; q_a returns read data one cycle after addr_a.
interface sprite_coord_fetch_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] addr_a;
  logic             rd_a;
  logic             we_a;
  logic [WIDTH-1:0] q_a;

  modport master (output addr_a, output rd_a, output we_a, input q_a);
  modport slave  (input addr_a, input rd_a, input we_a, output q_a);
endinterface

// File: rtl/sprite_coord_fetch.sv
// Vblank-triggered fetch of six sprite-coordinate words over memory port A, committed atomically.
// Optional macro SPRITE_CLAMP_EN clamps x/y words to the screen bounds at commit.
module sprite_coord_fetch #(
  parameter int WIDTH = 16,
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int MX    = 6000,
  parameter int MY    = 6004,
  parameter int P1X   = 6008,
  parameter int P1Y   = 6012,
  parameter int P2X   = 6016,
  parameter int P2Y   = 6020
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vblank,
  input  logic                 fetch_en,
  sprite_coord_fetch_if.master mem,
  output logic                 busy,
  output logic                 frame_done,
  output logic [WIDTH-1:0]     mx,
  output logic [WIDTH-1:0]     my,
  output logic [WIDTH-1:0]     p1x,
  output logic [WIDTH-1:0]     p1y,
  output logic [WIDTH-1:0]     p2x,
  output logic [WIDTH-1:0]     p2y
);

`ifdef SPRITE_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  localparam logic [WIDTH-1:0] X_MAX = WIDTH'(H_RES - 1);
  localparam logic [WIDTH-1:0] Y_MAX = WIDTH'(V_RES - 1);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t           state, state_nxt;
  logic [2:0]       idx;
  logic             vblank_q;
  logic             start;
  logic             last;
  logic [WIDTH-1:0] stage [6];

  function automatic logic [WIDTH-1:0] word_addr(input logic [2:0] i);
    case (i)
      3'd0:    return WIDTH'(MX);
      3'd1:    return WIDTH'(MY);
      3'd2:    return WIDTH'(P1X);
      3'd3:    return WIDTH'(P1Y);
      3'd4:    return WIDTH'(P2X);
      3'd5:    return WIDTH'(P2Y);
      default: return '0;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] clamp_x(input logic [WIDTH-1:0] w);
    return (CLAMP_EN && (w > X_MAX)) ? X_MAX : w;
  endfunction

  function automatic logic [WIDTH-1:0] clamp_y(input logic [WIDTH-1:0] w);
    return (CLAMP_EN && (w > Y_MAX)) ? Y_MAX : w;
  endfunction

  assign start = vblank & ~vblank_q & fetch_en & (state == IDLE);
  assign last  = (state == FETCH) && (idx == 3'd6);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == FETCH);
    mem.rd_a   = (state == FETCH) && (idx <= 3'd5);
    mem.addr_a = mem.rd_a ? word_addr(idx) : '0;
    mem.we_a   = 1'b0;
  end

  // Read data lags the address by one cycle, so cycle idx captures the word addressed at idx-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vblank_q   <= 1'b0;
      idx        <= '0;
      frame_done <= 1'b0;
      // NOTE: the staging array is a handful of flops, reset so an aborted fetch leaves nothing behind.
      for (int i = 0; i < 6; i++) stage[i] <= '0;
      mx  <= '0;
      my  <= '0;
      p1x <= '0;
      p1y <= '0;
      p2x <= '0;
      p2y <= '0;
    end else begin
      vblank_q   <= vblank;
      frame_done <= last;
      if (start)               idx <= '0;
      else if (state == FETCH) idx <= last ? 3'd0 : idx + 3'd1;
      if ((state == FETCH) && (idx != 3'd0)) stage[idx - 3'd1] <= mem.q_a;
      if (last) begin
        mx  <= clamp_x(stage[0]);
        my  <= clamp_y(stage[1]);
        p1x <= clamp_x(stage[2]);
        p1y <= clamp_y(stage[3]);
        p2x <= clamp_x(stage[4]);
        p2y <= clamp_y(mem.q_a);
      end
    end
  end

endmodule

// File: tb/tb_sprite_coord_fetch.sv
// Self-checking bench for sprite_coord_fetch: vector table plus hand-written corner sequences,
// with a scoreboard of expected read addresses and committed coordinate sets.
module tb_sprite_coord_fetch;
  typedef logic [5:0][15:0] coords_t;  // [0]=mx .. [5]=p2y
  typedef struct {
    coords_t w;
    bit      en;
  } vec_t;

  logic clk = 1'b0;
  logic reset, vblank, fetch_en;
  logic busy, frame_done;
  logic [15:0] mx, my, p1x, p1y, p2x, p2y;
  logic [15:0] mem_words [6];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int frame_cnt = 0;
  int start_cyc = 0;
  int run_len = 0;
  int busy_len = 0;
  bit in_run = 0;
  coords_t prev_out = '0;
  coords_t model_out = '0;
  logic [15:0] addr_q [$];
  coords_t coord_q [$];
  vec_t vecs [6];

  sprite_coord_fetch_if #(.WIDTH(16)) bus ();

  sprite_coord_fetch dut (
    .clk(clk), .reset(reset), .vblank(vblank), .fetch_en(fetch_en), .mem(bus),
    .busy(busy), .frame_done(frame_done),
    .mx(mx), .my(my), .p1x(p1x), .p1y(p1y), .p2x(p2x), .p2y(p2y)
  );

  always #10 clk = ~clk;

  // Synchronous-read RAM model covering the six coordinate words.
  always @(posedge clk) begin
    if (bus.rd_a && bus.addr_a >= 16'd6000 && bus.addr_a <= 16'd6020 && bus.addr_a[1:0] == 2'b00)
      bus.q_a <= mem_words[(bus.addr_a - 16'd6000) >> 2];
    else
      bus.q_a <= '0;
  end

  function automatic coords_t dut_out();
    coords_t c;
    c[0] = mx; c[1] = my; c[2] = p1x; c[3] = p1y; c[4] = p2x; c[5] = p2y;
    return c;
  endfunction

  function automatic coords_t mk(input logic [15:0] a, b, c, d, e, f);
    coords_t w;
    w[0] = a; w[1] = b; w[2] = c; w[3] = d; w[4] = e; w[5] = f;
    return w;
  endfunction

  function automatic coords_t model_commit(input coords_t w);
    coords_t r = w;
`ifdef SPRITE_CLAMP_EN
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0 && r[k] > 16'd639) r[k] = 16'd639;
      if (k % 2 == 1 && r[k] > 16'd479) r[k] = 16'd479;
    end
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic load_mem(input coords_t w);
    for (int k = 0; k < 6; k++) mem_words[k] = w[k];
  endtask

  task automatic expect_fetch(input coords_t w);
    for (int k = 0; k < 6; k++) addr_q.push_back(16'(6000 + 4 * k));
    model_out = model_commit(w);
    coord_q.push_back(model_out);
  endtask

  // Monitor: scoreboard pops, read-burst and busy lengths, commit latency, output stability.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      in_run = 0; run_len = 0; busy_len = 0;
      prev_out = dut_out();
    end else begin
      if (bus.rd_a) begin
        if (!in_run) begin start_cyc = cyc; run_len = 0; in_run = 1; end
        run_len++;
        if (addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read: got addr %0d required no read", bus.addr_a);
        end else check("addr_seq", bus.addr_a, addr_q.pop_front());
      end else if (in_run) begin
        check("rd_run_len", run_len, 6);
        in_run = 0;
      end
      if (busy) busy_len++;
      else if (busy_len != 0) begin check("busy_len", busy_len, 7); busy_len = 0; end
      check("we_a_zero", bus.we_a, 0);
      if (frame_done) begin
        frame_cnt++;
        check("done_latency", cyc - start_cyc, 7);
        if (coord_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_commit: got %0h required no commit", dut_out());
        end else check("commit", dut_out(), coord_q.pop_front());
      end else check("stable", dut_out(), prev_out);
      prev_out = dut_out();
    end
  end

  initial begin
    int base;
    vecs[0] = '{w: mk(10, 20, 30, 40, 50, 60), en: 1'b1};
    vecs[1] = '{w: mk(99, 99, 99, 99, 99, 99), en: 1'b0};
    vecs[2] = '{w: mk(700, 500, 100, 200, 900, 1000), en: 1'b1};
    vecs[3] = '{w: mk(639, 479, 640, 480, 0, 0), en: 1'b1};
    vecs[4] = '{w: mk(16'hffff, 16'hffff, 16'hffff, 16'hffff, 16'hffff, 16'hffff), en: 1'b1};
    vecs[5] = '{w: mk(1, 2, 3, 4, 5, 6), en: 1'b1};

    reset = 1'b1; vblank = 1'b0; fetch_en = 1'b0;
    load_mem('0);
    #3;
    check("reset_outputs", dut_out(), 0);
    check("reset_flags", {busy, frame_done, bus.rd_a, bus.addr_a}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vblank = 1'b0;
      load_mem(vecs[i].w);
      fetch_en = vecs[i].en;
      if (vecs[i].en) expect_fetch(vecs[i].w);
      base = frame_cnt;
      repeat (2) @(negedge clk);
      vblank = 1'b1;
      @(negedge clk);
      check($sformatf("start_busy_%0d", i), busy, vecs[i].en);
      repeat (10) @(negedge clk);
      check($sformatf("frames_%0d", i), frame_cnt - base, vecs[i].en);
      check($sformatf("coords_%0d", i), dut_out(), model_out);
    end

    // Retoggle vblank mid-fetch, then hold it high: exactly one fetch.
    vblank = 1'b0; fetch_en = 1'b1;
    load_mem(mk(11, 22, 33, 44, 55, 66));
    expect_fetch(mk(11, 22, 33, 44, 55, 66));
    base = frame_cnt;
    repeat (2) @(negedge clk);
    vblank = 1'b1;
    repeat (3) @(negedge clk);
    vblank = 1'b0;
    @(negedge clk);
    vblank = 1'b1;
    repeat (1000) @(negedge clk);
    check("retrigger_frames", frame_cnt - base, 1);
    check("retrigger_coords", dut_out(), model_out);

    // fetch_en and vblank both fall mid-fetch: the fetch still completes.
    vblank = 1'b0;
    repeat (2) @(negedge clk);
    load_mem(mk(7, 8, 9, 10, 11, 12));
    expect_fetch(mk(7, 8, 9, 10, 11, 12));
    base = frame_cnt;
    vblank = 1'b1;
    repeat (3) @(negedge clk);
    fetch_en = 1'b0; vblank = 1'b0;
    repeat (10) @(negedge clk);
    check("late_drop_frames", frame_cnt - base, 1);
    check("late_drop_coords", dut_out(), model_out);
    fetch_en = 1'b1;

    // Reset at idx=3 aborts the fetch and clears everything immediately.
    repeat (2) @(negedge clk);
    load_mem(mk(100, 200, 300, 400, 500, 600));
    expect_fetch(mk(100, 200, 300, 400, 500, 600));
    vblank = 1'b1;
    repeat (4) @(negedge clk);
    check("idx3_addr", bus.addr_a, 6012);
    #2;
    reset = 1'b1; vblank = 1'b0;
    addr_q.delete(); coord_q.delete();
    model_out = '0;
    #1;
    check("async_reset_outputs", dut_out(), 0);
    check("async_reset_flags", {busy, frame_done, bus.rd_a}, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    base = frame_cnt;
    repeat (10) @(negedge clk);
    check("abort_frames", frame_cnt - base, 0);
    check("abort_coords", dut_out(), 0);

    load_mem(mk(700, 500, 100, 1, 2, 3));
    expect_fetch(mk(700, 500, 100, 1, 2, 3));
    base = frame_cnt;
    vblank = 1'b1;
    repeat (11) @(negedge clk);
    check("post_reset_frames", frame_cnt - base, 1);
    check("post_reset_coords", dut_out(), model_out);
    check("scoreboard_empty", addr_q.size() + coord_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sprite_coord_fetch.md
Name: sprite_coord_fetch

Overview:
Frame-synchronous fetch controller for the sprite-coordinate words that the CPU writes into shared memory at MX..P2Y. On each vertical-blank entry it sequences six reads on the otherwise unused memory port A, stages the words, and commits them atomically to coordinate registers driving the VGA renderer. The renderer therefore never sees a half-updated frame, and the CPU's port B is never stalled.

Parameters:
WIDTH, 16, data and address width
H_RES, 640, horizontal resolution (clamp bound)
V_RES, 480, vertical resolution (clamp bound)
MX, 6000, address of mario x word
MY, 6004, address of mario y word
P1X, 6008, address of player-1 x word
P1Y, 6012, address of player-1 y word
P2X, 6016, address of player-2 x word
P2Y, 6020, address of player-2 y word

Ports:
clk  input  1  system clock (50 MHz)
reset  input  1  asynchronous, active-high reset
vblank  input  1  level, high during vertical blank (synchronous to clk)
fetch_en  input  1  level; when low, no new fetch starts
q_a  input  WIDTH  memory port A read data; valid one cycle after addr_a
addr_a  output  WIDTH  memory port A address
rd_a  output  1  high in cycles where addr_a is a valid read
we_a  output  1  port A write enable; constant 0
busy  output  1  high while FETCH is active
frame_done  output  1  one-cycle pulse after commit
mx, my, p1x, p1y, p2x, p2y  output  WIDTH each  committed coordinates

Behaviour:
- Reset (async, active-high) sets all of the following to 0: outputs, staging registers, index counter and vblank_q. State goes to IDLE. Assertion mid-fetch aborts the fetch and discards staged data.
- Edge detect: vblank_q is vblank registered on clk. The start condition is vblank & ~vblank_q & fetch_en & (state==IDLE), evaluated at clock edge E0.
- States:
  - IDLE: busy=0, rd_a=0, addr_a=0. On the start condition, go to FETCH with idx=0.
  - FETCH: lasts 7 cycles, idx 0..6, with idx incrementing each cycle.
    - For idx 0..5: rd_a=1 and addr_a = {MX,MY,P1X,P1Y,P2X,P2Y}[idx].
    - For idx 1..6: q_a is captured into stage[idx-1] at the end of the cycle.
    - idx 6: rd_a=0 and addr_a=0. At the end of this cycle, the last word is captured and all six outputs load from staging in the same edge (atomic commit). State goes to IDLE.
  - frame_done is high for exactly the one cycle following the commit edge (E7).
- Latency: outputs change at E7, i.e. 7 cycles after the edge that detected vblank rise. busy is high during cycles 1..7.
- A vblank rising edge while busy=1 is ignored, not queued.
- If fetch_en falls mid-fetch, the fetch completes normally.
- If vblank falls mid-fetch, the fetch completes normally.
- If vblank is held high, there is no retrigger; only one fetch per rising edge.
- If fetch_en is low at the vblank rise, that frame is skipped. The outputs hold their previous values.
- Between commits the outputs are stable; they change only at a commit edge or on reset.
- Addresses are driven unchanged as WIDTH-bit values; no word/byte conversion is done.
- we_a is tied to 0; the block never writes memory.

Optional Feature:
Macro SPRITE_CLAMP_EN.
- Defined: at commit, x words greater than H_RES-1 load as H_RES-1, and y words greater than V_RES-1 load as V_RES-1. Comparison is unsigned.
- Undefined: words commit unmodified.
Timing is identical in both builds.

Test Plan:
1. Reset check: assert reset asynchronously between clock edges -> all outputs, busy, frame_done and rd_a read 0 immediately.
2. Basic fetch: memory holds 6000=10, 6004=20, 6008=30, 6012=40, 6016=50, 6020=60; fetch_en=1; raise vblank. Required response:
   - addr_a sequence is 6000,6004,6008,6012,6016,6020 on consecutive cycles with rd_a=1.
   - busy is high for 7 cycles.
   - All outputs become 10..60 at E7 together.
   - frame_done pulses once.
3. Ignore while busy / no retrigger: toggle vblank low then high again 3 cycles into a fetch -> no second fetch, exactly one frame_done. Holding vblank high for 1000 cycles also produces exactly one fetch.
4. fetch_en low: change memory to 99s, set fetch_en=0, raise vblank -> rd_a stays 0, outputs hold 10..60, no frame_done.
5. Reset mid-fetch: assert reset at idx=3 -> outputs are 0, state is IDLE, and no frame_done. On the next vblank rise, a full fetch loads the current memory values.
6. Clamp build (SPRITE_CLAMP_EN): mx word=700 and my word=500 commit as 639 and 479, while p1x=100 commits unchanged. In the unclamped build, 700 and 500 pass through.
